// File: rtl/kgs_accum_seq.sv
// kgs_accum_seq: sequencing stage around the combinational KGS tree adder.
// It takes a burst of operands over a valid/ready stream and presents each one
// to the adder against the running accumulator. The adder sum is folded back
// into the accumulator, and carry/borrow-out events are counted as wraps.
// The final value and the wrap count leave on a valid/ready result port.
module kgs_accum_seq #(
  parameter int SIZE  = 32,
  parameter int LEN_W = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [SIZE-1:1]   in_data,
  input  logic              in_sub,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SIZE-1:1]   add_a,
  output logic [SIZE-1:1]   add_b,
  output logic              add_cin,
  input  logic [SIZE-1:1]   add_sum,
  input  logic              add_cout,
  output logic [SIZE-1:1]   res_data,
  output logic [CNT_W-1:0]  res_wraps,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  localparam int W = SIZE - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   wraps_q, wraps_d;
  logic               wrap_evt;

  // Next-state, datapath and output decode for the burst sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    wraps_d     = wraps_q;
    wrap_evt    = 1'b0;
    in_ready    = 1'b0;
    add_a       = acc_q;
    add_b       = '0;
    add_cin     = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_wraps   = '0;
    busy        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d       = '0;
          wraps_d     = '0;
          remaining_d = len;
          // A zero-length burst has nothing to accumulate: go straight to the result.
          state_d     = (len == '0) ? S_DONE : S_ACCUM;
        end
      end

      S_ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // Subtraction is acc + ~x + 1, so the adder carry-in carries the +1.
        add_b    = in_sub ? ~in_data : in_data;
        add_cin  = in_sub;
        if (in_valid) begin
          acc_d       = add_sum;
          remaining_d = remaining_q - LEN_W'(1);
          // Add wraps on carry-out; subtract wraps on borrow (carry-out low).
          wrap_evt    = in_sub ^ add_cout;
          if (wrap_evt && (wraps_q != {CNT_W{1'b1}})) begin
            wraps_d = wraps_q + CNT_W'(1);
          end
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = acc_q;
        res_wraps = wraps_q;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples its
    // pre-edge inputs, independent of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      wraps_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      wraps_q     <= wraps_d;
    end
  end

endmodule

// File: tb/tb_kgs_accum_seq.sv
// Testbench for kgs_accum_seq. A behavioural KGS adder closes the loop. A
// scoreboard queue holds the expected result of each burst, computed from the
// operand list when the burst starts, and is popped at the result handshake.
module tb_kgs_accum_seq;

  localparam int SIZE  = 32;
  localparam int LEN_W = 8;
  localparam int CNT_W = 4;
  localparam int W     = SIZE - 1;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [CNT_W-1:0] wraps;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [SIZE-1:1]   in_data;
  logic              in_sub;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:1]   add_a;
  logic [SIZE-1:1]   add_b;
  logic              add_cin;
  logic [SIZE-1:1]   add_sum;
  logic              add_cout;
  logic [SIZE-1:1]   res_data;
  logic [CNT_W-1:0]  res_wraps;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0]     op_q[$];
  logic             sub_q[$];
  res_t             exp_q[$];
  logic [W-1:0]     m_acc;
  logic [CNT_W-1:0] m_wraps;

  kgs_accum_seq #(.SIZE(SIZE), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .res_data  (res_data),
    .res_wraps (res_wraps),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the KGS tree adder.
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference step: add with carry detect, or subtract with borrow detect.
  function automatic void model_step(inout logic [W-1:0] acc, inout logic [CNT_W-1:0] w,
                                     input logic [W-1:0] d, input logic s);
    logic       wrap;
    logic [W:0] t;
    if (s) begin
      wrap = (d > acc);
      acc  = acc - d;
    end else begin
      t    = {1'b0, acc} + {1'b0, d};
      wrap = t[W];
      acc  = t[W-1:0];
    end
    if (wrap && (w != {CNT_W{1'b1}})) w = w + CNT_W'(1);
  endfunction

  task automatic plan_op(input logic [W-1:0] d, input logic s);
    op_q.push_back(d);
    sub_q.push_back(s);
  endtask

  task automatic start_burst();
    logic [W-1:0]     a = '0;
    logic [CNT_W-1:0] w = '0;
    res_t             r;
    foreach (op_q[i]) model_step(a, w, op_q[i], sub_q[i]);
    r.data  = a;
    r.wraps = w;
    exp_q.push_back(r);
    m_acc   = '0;
    m_wraps = '0;
    start = 1'b1;
    len   = LEN_W'(op_q.size());
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic drive_op(input logic [W-1:0] d, input logic s);
    int           n = 0;
    logic [W-1:0] b_exp;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("op_in_ready", in_ready, 1);
    b_exp = s ? ~d : d;
    check("op_add_b", add_b, b_exp);
    check("op_add_cin", add_cin, s);
    check("op_acc", add_a, m_acc);
    check("op_res_valid", res_valid, 0);
    @(posedge clk); #1;
    model_step(m_acc, m_wraps, d, s);
    in_valid = 1'b0;
    in_data  = '0;
    in_sub   = 1'b0;
  endtask

  // Feed the planned operands, inserting 'gap' idle cycles (with a stray start) between them.
  task automatic feed_all(input int gap);
    int n = op_q.size();
    for (int i = 0; i < n; i++) begin
      drive_op(op_q[i], sub_q[i]);
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = 1'b1;
          len   = 8'd5;
          @(negedge clk);
          check("gap_in_ready", in_ready, 1);
          check("gap_acc_held", add_a, m_acc);
          @(posedge clk); #1;
          start = 1'b0;
          len   = '0;
        end
      end
    end
    @(negedge clk);
    check("latency_res_valid", res_valid, 1);
    op_q.delete();
    sub_q.delete();
  endtask

  // Wait for the result, hold res_ready low 'hold' cycles, then consume it.
  task automatic collect(input int hold);
    int   n = 0;
    res_t e = '0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", res_valid, 1);
    check("sb_has_entry", (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("res_data", res_data, e.data);
    check("res_wraps", res_wraps, e.wraps);
    check("done_busy", busy, 1);
    check("done_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, e.data);
      check("hold_res_wraps", res_wraps, e.wraps);
      start = 1'b0;
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("exit_res_valid", res_valid, 0);
    check("exit_busy", busy, 0);
    check("exit_in_ready", in_ready, 0);
    check("exit_res_data", res_data, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    m_acc     = '0;
    m_wraps   = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_wraps", res_wraps, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Plain add.
    plan_op(31'h1E0, 1'b0);
    plan_op(31'h00F, 1'b0);
    start_burst();
    feed_all(0);
    collect(0);

    // Carry-out wrap.
    plan_op(31'h7FFF_FFFF, 1'b0);
    plan_op(31'h1, 1'b0);
    start_burst();
    feed_all(0);
    collect(0);

    // Subtract with borrow.
    plan_op(31'h5, 1'b0);
    plan_op(31'h7, 1'b1);
    start_burst();
    feed_all(0);
    collect(0);

    // Gapped operands and a stalled result port, with stray starts.
    plan_op(31'h10, 1'b0);
    plan_op(31'h20, 1'b0);
    plan_op(31'h30, 1'b1);
    start_burst();
    feed_all(2);
    collect(3);

    // Zero-length burst.
    start_burst();
    @(negedge clk);
    check("len0_res_valid", res_valid, 1);
    collect(0);

    // Wrap counter saturation: every subtraction borrows.
    for (int i = 0; i < 17; i++) plan_op(31'h7FFF_FFFF, 1'b1);
    start_burst();
    feed_all(0);
    collect(0);

    // Abort mid-burst with reset, then a clean burst.
    start = 1'b1;
    len   = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
    m_acc   = '0;
    m_wraps = '0;
    drive_op(31'h9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_acc", add_a, 0);
    check("abort_res_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_busy", busy, 0);
    plan_op(31'h3, 1'b0);
    plan_op(31'h4, 1'b0);
    start_burst();
    feed_all(0);
    collect(0);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
